// File: rtl/galvani_spi_slave.sv
// galvani_spi_slave
// Stimulator-side receiver for the 4-lane SPI command link. All serial inputs
// are oversampled in the CLK domain, one WORD_BITS word is deserialized per
// lane per frame, decoded into per-lane shadow registers, and committed to the
// active registers on a TRG_SLV rising edge.
//
// Ports:
//   CLK, RST          oversampling clock, synchronous active-high reset
//   SCLK, CSb, MOSI   serial clock, frame select (active low), per-lane data
//   RST_SLV           level-sensitive slave reset (clears shadows/actives/RX_CMD)
//   TRG_SLV           commit strobe, rising edge loads ACT_* from shadows
//   RX_CMD            last good raw word per lane, lane k at [16k+15:16k]
//   RX_VALID          one-cycle pulse per accepted frame
//   FRAME_ERR         one-cycle pulse per frame with the wrong bit count
//   ACT_*             active decoded fields per lane
//   UPDATE            one-cycle pulse when ACT_* load
module galvani_spi_slave #(
    parameter int unsigned N_LANES     = 4,
    parameter int unsigned WORD_BITS   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           SCLK,
    input  logic                           CSb,
    input  logic                           RST_SLV,
    input  logic                           TRG_SLV,
    input  logic [N_LANES-1:0]             MOSI,
    output logic [N_LANES*WORD_BITS-1:0]   RX_CMD,
    output logic                           RX_VALID,
    output logic                           FRAME_ERR,
    output logic [N_LANES-1:0]             ACT_MODE,
    output logic [N_LANES-1:0]             ACT_BIAS_SEL,
    output logic [N_LANES*7-1:0]           ACT_BIAS_AMP,
    output logic [N_LANES*5-1:0]           ACT_ADDR,
    output logic [N_LANES*8-1:0]           ACT_AMP,
    output logic                           UPDATE
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;

    // Synchronizer bundle layout: {MOSI, TRG_SLV, RST_SLV, CSb, SCLK}
    localparam int unsigned SW = N_LANES + 4;
    localparam logic [SW-1:0] IdleLvl = SW'(2);  // CSb idles high, all else low
    // Edge-detect copies: {TRG_SLV, CSb, SCLK}
    localparam logic [2:0] IdleEdge = 3'b010;

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
    logic [2:0]                     prev_q, prev_d;

    logic [1:0] state_q, state_d;
    logic [4:0] count_q, count_d;

    logic [N_LANES-1:0][WORD_BITS-1:0] shift_q, shift_d;
    logic [N_LANES-1:0][WORD_BITS-1:0] rx_cmd_q, rx_cmd_d;
    logic rx_valid_q, rx_valid_d;
    logic frame_err_q, frame_err_d;
    logic update_q, update_d;

    logic [N_LANES-1:0]      sh_mode_q, sh_mode_d, sh_bsel_q, sh_bsel_d;
    logic [N_LANES-1:0][6:0] sh_bamp_q, sh_bamp_d;
    logic [N_LANES-1:0][4:0] sh_addr_q, sh_addr_d;
    logic [N_LANES-1:0][7:0] sh_amp_q, sh_amp_d;

    logic [N_LANES-1:0]      act_mode_q, act_mode_d, act_bsel_q, act_bsel_d;
    logic [N_LANES-1:0][6:0] act_bamp_q, act_bamp_d;
    logic [N_LANES-1:0][4:0] act_addr_q, act_addr_d;
    logic [N_LANES-1:0][7:0] act_amp_q, act_amp_d;

    logic [SW-1:0]      sync_out;
    logic [N_LANES-1:0] mosi_s;
    logic               rst_slv_s, sclk_rise, csb_fall, csb_rise, trg_rise;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign mosi_s    = sync_out[SW-1:4];
    assign rst_slv_s = sync_out[2];
    assign sclk_rise =  sync_out[0] & ~prev_q[0];
    assign csb_fall  = ~sync_out[1] &  prev_q[1];
    assign csb_rise  =  sync_out[1] & ~prev_q[1];
    assign trg_rise  =  sync_out[3] & ~prev_q[2];

    always_comb begin
        sync_d[0] = {MOSI, TRG_SLV, RST_SLV, CSb, SCLK};
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = {sync_out[3], sync_out[1], sync_out[0]};
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_d     = shift_q;
        rx_cmd_d    = rx_cmd_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        update_d    = 1'b0;
        sh_mode_d   = sh_mode_q;
        sh_bsel_d   = sh_bsel_q;
        sh_bamp_d   = sh_bamp_q;
        sh_addr_d   = sh_addr_q;
        sh_amp_d    = sh_amp_q;
        act_mode_d  = act_mode_q;
        act_bsel_d  = act_bsel_q;
        act_bamp_d  = act_bamp_q;
        act_addr_d  = act_addr_q;
        act_amp_d   = act_amp_q;

        if (rst_slv_s) begin
            // Partial frames are dropped silently; serial activity is ignored.
            state_d    = StIdle;
            rx_cmd_d   = '0;
            sh_mode_d  = '0;
            sh_bsel_d  = '0;
            sh_bamp_d  = '0;
            sh_addr_d  = '0;
            sh_amp_d   = '0;
            act_mode_d = '0;
            act_bsel_d = '0;
            act_bamp_d = '0;
            act_addr_d = '0;
            act_amp_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (csb_fall) begin
                        count_d = '0;
                        shift_d = '0;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (sclk_rise) begin
                        for (int unsigned k = 0; k < N_LANES; k++) begin
                            shift_d[k] = {shift_q[k][WORD_BITS-2:0], mosi_s[k]};
                        end
                        count_d = (count_q == 5'd31) ? count_q : count_q + 5'd1;
                    end
                    if (csb_rise) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (count_q == 5'(WORD_BITS)) begin
                        rx_cmd_d   = shift_q;
                        rx_valid_d = 1'b1;
                        // Bias words touch only bias fields, amplitude words only
                        // address/amplitude; the untouched fields are held.
                        for (int unsigned k = 0; k < N_LANES; k++) begin
                            sh_mode_d[k] = shift_q[k][15];
                            if (!shift_q[k][15]) begin
                                sh_bsel_d[k] = shift_q[k][14];
                                sh_bamp_d[k] = shift_q[k][13:7];
                            end else begin
                                sh_addr_d[k] = shift_q[k][14:10];
                                sh_amp_d[k]  = shift_q[k][7:0];
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // Commit from the next-state shadows so a trigger coinciding with
            // frame acceptance picks up the freshly decoded word.
            if (trg_rise) begin
                act_mode_d = sh_mode_d;
                act_bsel_d = sh_bsel_d;
                act_bamp_d = sh_bamp_d;
                act_addr_d = sh_addr_d;
                act_amp_d  = sh_amp_d;
                update_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q      <= {SYNC_STAGES{IdleLvl}};
            prev_q      <= IdleEdge;
            state_q     <= StIdle;
            count_q     <= '0;
            shift_q     <= '0;
            rx_cmd_q    <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            update_q    <= 1'b0;
            sh_mode_q   <= '0;
            sh_bsel_q   <= '0;
            sh_bamp_q   <= '0;
            sh_addr_q   <= '0;
            sh_amp_q    <= '0;
            act_mode_q  <= '0;
            act_bsel_q  <= '0;
            act_bamp_q  <= '0;
            act_addr_q  <= '0;
            act_amp_q   <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            rx_cmd_q    <= rx_cmd_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            update_q    <= update_d;
            sh_mode_q   <= sh_mode_d;
            sh_bsel_q   <= sh_bsel_d;
            sh_bamp_q   <= sh_bamp_d;
            sh_addr_q   <= sh_addr_d;
            sh_amp_q    <= sh_amp_d;
            act_mode_q  <= act_mode_d;
            act_bsel_q  <= act_bsel_d;
            act_bamp_q  <= act_bamp_d;
            act_addr_q  <= act_addr_d;
            act_amp_q   <= act_amp_d;
        end
    end

    assign RX_CMD       = rx_cmd_q;
    assign RX_VALID     = rx_valid_q;
    assign FRAME_ERR    = frame_err_q;
    assign UPDATE       = update_q;
    assign ACT_MODE     = act_mode_q;
    assign ACT_BIAS_SEL = act_bsel_q;
    assign ACT_BIAS_AMP = act_bamp_q;
    assign ACT_ADDR     = act_addr_q;
    assign ACT_AMP      = act_amp_q;

endmodule

// File: tb/tb_galvani_spi_slave.sv
// Self-checking bench for galvani_spi_slave: directed test-plan frames plus
// random frames checked against a field-level scoreboard of shadow/active
// state per lane.
module tb_galvani_spi_slave;

    localparam int NL = 4;

    logic          CLK = 1'b0;
    logic          RST, SCLK, CSb, RST_SLV, TRG_SLV;
    logic [NL-1:0] MOSI;
    logic [NL*16-1:0] RX_CMD;
    logic          RX_VALID, FRAME_ERR, UPDATE;
    logic [NL-1:0] ACT_MODE, ACT_BIAS_SEL;
    logic [NL*7-1:0] ACT_BIAS_AMP;
    logic [NL*5-1:0] ACT_ADDR;
    logic [NL*8-1:0] ACT_AMP;

    galvani_spi_slave dut (
        .CLK          (CLK),
        .RST          (RST),
        .SCLK         (SCLK),
        .CSb          (CSb),
        .RST_SLV      (RST_SLV),
        .TRG_SLV      (TRG_SLV),
        .MOSI         (MOSI),
        .RX_CMD       (RX_CMD),
        .RX_VALID     (RX_VALID),
        .FRAME_ERR    (FRAME_ERR),
        .ACT_MODE     (ACT_MODE),
        .ACT_BIAS_SEL (ACT_BIAS_SEL),
        .ACT_BIAS_AMP (ACT_BIAS_AMP),
        .ACT_ADDR     (ACT_ADDR),
        .ACT_AMP      (ACT_AMP),
        .UPDATE       (UPDATE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_bad    = 0;

    // Pulse monitor
    int rxv_cnt = 0, ferr_cnt = 0, upd_cnt = 0, coin_cnt = 0;
    logic [4:0] coin_addr = '0;
    logic [7:0] coin_amp  = '0;
    always @(negedge CLK) begin
        if (RX_VALID)  rxv_cnt  <= rxv_cnt + 1;
        if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
        if (UPDATE)    upd_cnt  <= upd_cnt + 1;
        if (RX_VALID && UPDATE) begin
            coin_cnt  <= coin_cnt + 1;
            coin_addr <= ACT_ADDR[4:0];
            coin_amp  <= ACT_AMP[7:0];
        end
    end

    // Scoreboard: decoded fields per lane
    logic       sh_mode[NL], sh_bsel[NL], ac_mode[NL], ac_bsel[NL];
    logic [6:0] sh_bamp[NL], ac_bamp[NL];
    logic [4:0] sh_addr[NL], ac_addr[NL];
    logic [7:0] sh_amp[NL],  ac_amp[NL];
    logic [15:0] m_rx[NL];
    int exp_rxv = 0, exp_ferr = 0, exp_upd = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NL; k++) begin
            sh_mode[k] = 0; sh_bsel[k] = 0; sh_bamp[k] = 0; sh_addr[k] = 0; sh_amp[k] = 0;
            ac_mode[k] = 0; ac_bsel[k] = 0; ac_bamp[k] = 0; ac_addr[k] = 0; ac_amp[k] = 0;
            m_rx[k] = 0;
        end
    endtask

    task automatic apply_model(input logic [63:0] words);
        logic [15:0] w;
        for (int k = 0; k < NL; k++) begin
            w = words[16*k +: 16];
            m_rx[k] = w;
            if (w[15] == 1'b0) begin
                sh_mode[k] = 1'b0;
                sh_bsel[k] = w[14];
                sh_bamp[k] = w[13:7];
            end else begin
                sh_mode[k] = 1'b1;
                sh_addr[k] = w[14:10];
                sh_amp[k]  = w[7:0];
            end
        end
        exp_rxv++;
    endtask

    task automatic commit_model();
        for (int k = 0; k < NL; k++) begin
            ac_mode[k] = sh_mode[k]; ac_bsel[k] = sh_bsel[k]; ac_bamp[k] = sh_bamp[k];
            ac_addr[k] = sh_addr[k]; ac_amp[k]  = sh_amp[k];
        end
        exp_upd++;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] e_rx, e_mode, e_bsel, e_bamp, e_addr, e_amp;
        e_rx = '0; e_mode = '0; e_bsel = '0; e_bamp = '0; e_addr = '0; e_amp = '0;
        for (int k = 0; k < NL; k++) begin
            e_rx[16*k +: 16] = m_rx[k];
            e_mode[k]        = ac_mode[k];
            e_bsel[k]        = ac_bsel[k];
            e_bamp[7*k +: 7] = ac_bamp[k];
            e_addr[5*k +: 5] = ac_addr[k];
            e_amp[8*k +: 8]  = ac_amp[k];
        end
        check_eq({tag, ".rx_cmd"}, 64'(RX_CMD), e_rx);
        check_eq({tag, ".mode"},   64'(ACT_MODE), e_mode);
        check_eq({tag, ".bsel"},   64'(ACT_BIAS_SEL), e_bsel);
        check_eq({tag, ".bamp"},   64'(ACT_BIAS_AMP), e_bamp);
        check_eq({tag, ".addr"},   64'(ACT_ADDR), e_addr);
        check_eq({tag, ".amp"},    64'(ACT_AMP), e_amp);
    endtask

    task automatic pulse_trg();
        TRG_SLV = 1'b1;
        clk(3);
        TRG_SLV = 1'b0;
        clk(6);
        commit_model();
    endtask

    // trg_mode: 0 none, 1 pulse during bit trg_bit, 2 rise one CLK after CSb
    // rises (coincides with acceptance), 3 pulse after the frame.
    // abort_at >= 0 asserts RST_SLV at that bit instead of finishing the frame.
    task automatic send_frame(input logic [63:0] words, input int nbits, input int trg_mode,
                              input int trg_bit, input int abort_at);
        int lat;
        bit got;
        CSb = 1'b0;
        clk(3);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                RST_SLV = 1'b1;
                clk(3);
                CSb = 1'b1;
                clk(6);
                RST_SLV = 1'b0;
                clk(6);
                clear_model();
                return;
            end
            for (int k = 0; k < NL; k++) begin
                MOSI[k] = (i < 16) ? words[16*k + 15 - i] : 1'($urandom);
            end
            if (trg_mode == 1 && i == trg_bit) TRG_SLV = 1'b1;
            clk(3);
            SCLK = 1'b1;
            TRG_SLV = 1'b0;
            if (trg_mode == 1 && i == trg_bit) commit_model();
            clk(3);
            SCLK = 1'b0;
        end
        clk(3);
        CSb = 1'b1;
        if (nbits == 16) begin
            got = 1'b0;
            lat = 0;
            for (int c = 1; c <= 10 && !got; c++) begin
                clk(1);
                if (c == 1 && trg_mode == 2) TRG_SLV = 1'b1;
                if (RX_VALID) begin
                    got = 1'b1;
                    lat = c;
                end
            end
            check_eq("rx_valid_latency", 64'(lat), 64'd4);
            apply_model(words);
            if (trg_mode == 2) commit_model();
            clk(4);
            TRG_SLV = 1'b0;
        end else begin
            clk(8);
            exp_ferr++;
        end
        clk(4);
        if (trg_mode == 3) pulse_trg();
    endtask

    initial begin
        logic [63:0] words;
        int ferr_before, rxv_before, coin_before, mode;

        RST = 1'b1; SCLK = 1'b0; CSb = 1'b1; RST_SLV = 1'b0; TRG_SLV = 1'b0; MOSI = '0;
        clear_model();
        clk(5);
        check_all("reset");
        check_eq("reset.rx_valid", 64'(RX_VALID), 64'd0);
        check_eq("reset.frame_err", 64'(FRAME_ERR), 64'd0);
        check_eq("reset.update", 64'(UPDATE), 64'd0);
        RST = 1'b0;
        clk(4);
        check_eq("post_reset.update", 64'(upd_cnt), 64'd0);

        // Bias word on all lanes, then commit
        words = {16'h2A00, 16'h7F80, 16'h0000, 16'h4A80};
        send_frame(words, 16, 0, 0, -1);
        check_eq("bias.rx_valid_cnt", 64'(rxv_cnt), 64'(exp_rxv));
        pulse_trg();
        check_all("bias");
        check_eq("bias.update_cnt", 64'(upd_cnt), 64'(exp_upd));
        check_eq("bias.lane0_bamp", 64'(ACT_BIAS_AMP[6:0]), 64'h15);
        check_eq("bias.lane3_bamp", 64'(ACT_BIAS_AMP[27:21]), 64'h54);

        // Amplitude word on lane 1, no trigger yet
        words = {16'h2A00, 16'h7F80, 16'hCCA5, 16'h4A80};
        send_frame(words, 16, 0, 0, -1);
        check_eq("amp.rx_cmd_lane1", 64'(RX_CMD[31:16]), 64'hCCA5);
        check_all("amp.pre_trg");
        pulse_trg();
        check_all("amp.post_trg");
        check_eq("amp.lane1_addr", 64'(ACT_ADDR[9:5]), 64'h13);
        check_eq("amp.lane1_amp", 64'(ACT_AMP[15:8]), 64'hA5);

        // Short and long frames
        rxv_before = rxv_cnt;
        send_frame(64'h1234_5678_9ABC_DEF0, 15, 0, 0, -1);
        check_eq("short.frame_err_cnt", 64'(ferr_cnt), 64'(exp_ferr));
        send_frame(64'hFFFF_8000_C3C3_0F0F, 17, 3, 0, -1);
        check_eq("long.frame_err_cnt", 64'(ferr_cnt), 64'(exp_ferr));
        check_eq("badlen.rx_valid_cnt", 64'(rxv_cnt), 64'(rxv_before));
        check_all("badlen");

        // Trigger coinciding with acceptance
        coin_before = coin_cnt;
        words = {16'h2A00, 16'h7F80, 16'hCCA5, 16'h8101};
        send_frame(words, 16, 2, 0, -1);
        check_eq("coin.count", 64'(coin_cnt - coin_before), 64'd1);
        check_eq("coin.lane0_addr", 64'(coin_addr), 64'h00);
        check_eq("coin.lane0_amp", 64'(coin_amp), 64'h01);
        check_all("coin");

        // RST_SLV after 8 bits
        ferr_before = ferr_cnt;
        send_frame(64'hAAAA_5555_F00F_8421, 16, 0, 0, 8);
        check_all("rst_slv");
        check_eq("rst_slv.no_frame_err", 64'(ferr_cnt), 64'(ferr_before));
        words = 64'h9C3A_2B80_C001_6F00;
        send_frame(words, 16, 3, 0, -1);
        check_all("rst_slv.next_frame");
        check_eq("rst_slv.rx_valid_cnt", 64'(rxv_cnt), 64'(exp_rxv));

        // Random frames with random trigger placement
        for (int f = 0; f < 50; f++) begin
            words = {$urandom, $urandom};
            mode = $urandom_range(0, 3);
            send_frame(words, 16, mode, $urandom_range(0, 15), -1);
            check_all("rand");
        end

        clk(4);
        check_eq("final.rx_valid_cnt", 64'(rxv_cnt), 64'(exp_rxv));
        check_eq("final.frame_err_cnt", 64'(ferr_cnt), 64'(exp_ferr));
        check_eq("final.update_cnt", 64'(upd_cnt), 64'(exp_upd));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
